// File: rtl/alu_dispatch.sv
// Two-stage issue/collect front end for the RISC-V ALU: decodes ALUOp/funct into ALUControl.
// Latency 2 cycles, 1 op/cycle; a stalled result holds both stages and drops in_ready once S1 is full.
module alu_dispatch (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_alu_op,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic        in_op5,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] alu_src_a,
   output logic [31:0] alu_src_b,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_taken,
   output logic        out_illegal,
   output logic [31:0] op_count
);

   localparam logic [2:0] CTL_ADD = 3'b000;
   localparam logic [2:0] CTL_SUB = 3'b001;
   localparam logic [2:0] CTL_AND = 3'b010;
   localparam logic [2:0] CTL_OR  = 3'b011;
   localparam logic [2:0] CTL_SRL = 3'b101;
   localparam logic [2:0] CTL_ILL = 3'b111;

   typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_kind_e;

   logic        s1_valid;
   br_kind_e    s1_br;
   logic        s1_illegal;

   logic [2:0]  dec_ctrl;
   br_kind_e    dec_br;
   logic        dec_illegal;
   logic [31:0] dec_src_b;
   logic        s2_taken;
   logic        s2_load;
   logic        accept;

   always_comb begin
      dec_ctrl = CTL_ILL;
      dec_br   = BR_NONE;
      case (in_alu_op)
         2'b00: dec_ctrl = CTL_ADD;
         2'b01: begin
            case (in_funct3)
               3'b000: begin dec_ctrl = CTL_SUB; dec_br = BR_EQ; end
               3'b001: begin dec_ctrl = CTL_SUB; dec_br = BR_NE; end
               default: ;
            endcase
         end
         2'b10: begin
            case (in_funct3)
               3'b000: dec_ctrl = (in_op5 & in_funct7b5) ? CTL_SUB : CTL_ADD;
               3'b111: dec_ctrl = CTL_AND;
               3'b110: dec_ctrl = CTL_OR;
               // funct7b5=1 here is sra, which the ALU does not implement
               3'b101: if (!in_funct7b5) dec_ctrl = CTL_SRL;
               default: ;
            endcase
         end
         default: ;
      endcase
      dec_illegal = (dec_ctrl == CTL_ILL);
      dec_src_b   = (dec_ctrl == CTL_SRL) ? {27'b0, in_b[4:0]} : in_b;
   end

   always_comb begin
      case (s1_br)
         BR_EQ:   s2_taken = alu_zero;
         BR_NE:   s2_taken = ~alu_zero;
         default: s2_taken = 1'b0;
      endcase
   end

   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s2_load;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_br       <= BR_NONE;
         s1_illegal  <= 1'b0;
         alu_src_a   <= '0;
         alu_src_b   <= '0;
         alu_control <= CTL_ILL;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_taken   <= 1'b0;
         out_illegal <= 1'b0;
         op_count    <= '0;
      end else begin
         if (accept) begin
            s1_valid    <= 1'b1;
            s1_br       <= dec_br;
            s1_illegal  <= dec_illegal;
            alu_src_a   <= in_a;
            alu_src_b   <= dec_src_b;
            alu_control <= dec_ctrl;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_load) begin
            out_valid   <= 1'b1;
            out_result  <= alu_result;
            out_zero    <= alu_zero;
            out_taken   <= s2_taken;
            out_illegal <= s1_illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (out_valid & out_ready) op_count <= op_count + 32'd1;
      end
   end

endmodule
